encoder_uart_streamer: RTL and testbench

- Downstream consumer of the 12 rotary-encoder counters (5-bit each, CLK domain) in the FPGA top level.
- Periodically snapshots all 12 counts coherently in one cycle.
- Streams the snapshot to the host MCU as a fixed 14-byte UART frame: sync, 12 data bytes, XOR checksum.
- Sits between the counter array and the TX pin; one instance serves all motors.

---
 rtl/encoder_uart_streamer.sv | 182 ++++++++++++++++++
 tb/tb_encoder_uart_streamer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_uart_streamer.sv
// Purpose: snapshots the 12 encoder counts on a periodic tick and streams them as a 14-byte 8N1 UART frame.
// Latency: frame starts on the tick edge; TX is busy for 140 bit periods, FRAME_DONE on the final stop-bit edge.
// Backpressure: none upstream; a tick arriving while a frame is in flight is dropped and flagged on FRAME_DROP.
module encoder_uart_streamer #(
   parameter int CLK_HZ              = 16000000,
   parameter int BAUD                = 115200,
   parameter int FRAME_PERIOD_CYCLES = 160000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [59:0] COUNTS,
   output logic        TX,
   output logic        BUSY,
   output logic        FRAME_DONE,
   output logic        FRAME_DROP
);

   // Bit period in clocks, rounded to nearest; must be at least 2.
   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int DW  = $clog2(DIV);
   localparam int PW  = (FRAME_PERIOD_CYCLES > 1) ? $clog2(FRAME_PERIOD_CYCLES) : 1;

   localparam logic [DW-1:0] BAUD_LAST   = DW'(DIV - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(FRAME_PERIOD_CYCLES - 1);
   localparam logic [7:0]    SYNC_BYTE   = 8'hA5;
   localparam logic [3:0]    CSUM_IDX    = 4'd12;  // byte index whose successor is the checksum
   localparam logic [3:0]    LAST_BYTE   = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] period_cnt;
   logic          tick;
   logic [DW-1:0] baud_cnt, baud_nxt;
   logic          bit_end;
   logic [2:0]    bit_idx, bit_nxt;
   logic [3:0]    byte_idx, byte_nxt;
   logic [7:0]    shreg, sh_nxt;
   logic [7:0]    csum, csum_nxt;
   logic [59:0]   shadow;
   logic [4:0]    chan_sel;
   logic [7:0]    next_byte;
   logic          capture;
   logic          tx_nxt, busy_nxt, done_nxt, drop_nxt;

   assign tick    = (period_cnt == PERIOD_LAST);
   assign bit_end = (baud_cnt == BAUD_LAST);

   // Free-running frame period counter, independent of EN and of the frame state.
   always_ff @(posedge CLK) begin
      if (RST || tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + PW'(1);
      end
   end

   // Snapshot register: loaded only on the edge that starts a frame, so live COUNTS never leak into a frame.
   always_ff @(posedge CLK) begin
      if (RST) begin
         shadow <= '0;
      end else if (capture) begin
         shadow <= COUNTS;
      end
   end

   // Select the snapshot channel that follows the current byte (byte_idx k loads channel k next).
   always_comb begin
      chan_sel = '0;
      for (int k = 0; k < 12; k++) begin
         if (byte_idx == 4'(k)) begin
            chan_sel = shadow[5*k +: 5];
         end
      end
   end

   assign next_byte = (byte_idx == CSUM_IDX) ? csum : {3'b000, chan_sel};

   // Next-state, datapath updates and registered-output values for the frame sequencer.
   always_comb begin
      state_nxt = state;
      baud_nxt  = bit_end ? '0 : baud_cnt + DW'(1);
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      sh_nxt    = shreg;
      csum_nxt  = csum;
      capture   = 1'b0;
      done_nxt  = 1'b0;
      drop_nxt  = tick && EN && (state != S_IDLE);
      tx_nxt    = 1'b1;
      busy_nxt  = 1'b0;

      case (state)
         S_IDLE: begin
            baud_nxt = '0;
            if (tick && EN) begin
               capture   = 1'b1;
               state_nxt = S_START;
               byte_nxt  = '0;
               sh_nxt    = SYNC_BYTE;
               csum_nxt  = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_nxt = S_DATA;
               bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end else begin
                  bit_nxt = bit_idx + 3'd1;
                  sh_nxt  = {1'b0, shreg[7:1]};
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (byte_idx != LAST_BYTE) begin
                  state_nxt = S_START;
                  byte_nxt  = byte_idx + 4'd1;
                  sh_nxt    = next_byte;
                  // The checksum byte itself must not fold into the running XOR.
                  if (byte_idx != CSUM_IDX) begin
                     csum_nxt = csum ^ next_byte;
                  end
               end else begin
                  state_nxt = S_IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (state_nxt == S_START) begin
         tx_nxt = 1'b0;
      end else if (state_nxt == S_DATA) begin
         tx_nxt = sh_nxt[0];
      end
      busy_nxt = (state_nxt != S_IDLE);
   end

   // State and output registers; reset aborts any frame in flight without a done pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         shreg      <= '0;
         csum       <= '0;
         TX         <= 1'b1;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
         FRAME_DROP <= 1'b0;
      end else begin
         state      <= state_nxt;
         baud_cnt   <= baud_nxt;
         bit_idx    <= bit_nxt;
         byte_idx   <= byte_nxt;
         shreg      <= sh_nxt;
         csum       <= csum_nxt;
         TX         <= tx_nxt;
         BUSY       <= busy_nxt;
         FRAME_DONE <= done_nxt;
         FRAME_DROP <= drop_nxt;
      end
   end

endmodule

// File: tb/tb_encoder_uart_streamer.sv
// Bench for encoder_uart_streamer: two instances (period 3000 and 2000) share stimulus.
// A time-indexed frame model predicts TX/BUSY/FRAME_DONE/FRAME_DROP every cycle; a UART decoder checks content.
// Edge numbering: edge 0 is the last edge with RST high; the tick at counter 2999 starts the frame on edge 3000.
`timescale 1ns/1ps
module tb_encoder_uart_streamer;

   localparam int CLK_HZ    = 1600;
   localparam int BAUD      = 100;
   localparam int DIV       = 16;
   localparam int FRAME_CYC = 140 * DIV;
   localparam int PER0      = 3000;
   localparam int PER1      = 2000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EN;
   logic [59:0] COUNTS;
   logic [1:0]  tx_w, busy_w, done_w, drop_w;

   always #5 CLK = ~CLK;

   encoder_uart_streamer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_PERIOD_CYCLES(PER0)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .COUNTS(COUNTS),
      .TX(tx_w[0]), .BUSY(busy_w[0]), .FRAME_DONE(done_w[0]), .FRAME_DROP(drop_w[0])
   );

   encoder_uart_streamer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_PERIOD_CYCLES(PER1)) dut_p2 (
      .CLK(CLK), .RST(RST), .EN(EN), .COUNTS(COUNTS),
      .TX(tx_w[1]), .BUSY(busy_w[1]), .FRAME_DONE(done_w[1]), .FRAME_DROP(drop_w[1])
   );

   int n_tests = 0;
   int n_fail  = 0;
   int ecount  = 0;

   // Reference model state per instance.
   int         per [2] = '{PER0, PER1};
   int         pc [2];
   int         ft [2];
   bit         mb [2];
   logic [7:0] fb [2][14];
   logic       e_tx [2], e_busy [2], e_done [2], e_drop [2];
   logic [111:0] exp_q [$];

   // Decoder / monitor state for instance 0.
   bit         dec_on = 1'b0;
   int         dec_t, dec_ferr, dec_bad, dec_fall, cur_fall, n_dec;
   logic [7:0] dec_cur [14];
   logic [7:0] last_dec [14];
   logic       prev_tx = 1'b1;
   int         busy_len, done_edge, n_done0;
   int         win_txlow, win_busy, win_drop;

   // Event log for instance 1.
   int   fall1_q [$];
   int   drop1_q [$];
   logic prev_busy1 = 1'b0;

   logic [7:0] s1_exp [14];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, ecount);
      end
   endtask

   function automatic logic frame_bit(input int i);
      int b, pos;
      b   = ft[i] / DIV;
      pos = b % 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return fb[i][b / 10][pos - 1];
   endfunction

   // One clock edge of the behavioural model, using the inputs as they stood at that edge.
   task automatic model_edge(input int i);
      bit           tick;
      logic [7:0]   x;
      logic [111:0] pk;
      if (RST) begin
         pc[i] = 0; mb[i] = 1'b0; ft[i] = 0; e_done[i] = 1'b0; e_drop[i] = 1'b0;
         if (i == 0) exp_q.delete();
      end else begin
         tick      = (pc[i] == per[i] - 1);
         pc[i]     = (pc[i] + 1) % per[i];
         e_done[i] = 1'b0;
         e_drop[i] = tick && EN && mb[i];
         if (mb[i]) begin
            ft[i]++;
            if (ft[i] == FRAME_CYC) begin
               mb[i] = 1'b0;
               e_done[i] = 1'b1;
            end
         end else if (tick && EN) begin
            x = 8'h00;
            fb[i][0] = 8'hA5;
            for (int k = 0; k < 12; k++) begin
               fb[i][k+1] = {3'b000, COUNTS[5*k +: 5]};
               x = x ^ fb[i][k+1];
            end
            fb[i][13] = x;
            mb[i] = 1'b1;
            ft[i] = 0;
            if (i == 0) begin
               for (int n = 0; n < 14; n++) pk[8*n +: 8] = fb[0][n];
               exp_q.push_back(pk);
            end
         end
      end
      e_busy[i] = mb[i];
      e_tx[i]   = mb[i] ? frame_bit(i) : 1'b1;
   endtask

   task automatic finish_frame();
      logic [111:0] pk;
      n_dec++;
      dec_fall = cur_fall;
      for (int n = 0; n < 14; n++) last_dec[n] = dec_cur[n];
      chk_eq("dec_framing_errors", dec_ferr, 0);
      chk_eq("dec_off_grid_transitions", dec_bad, 0);
      chk_eq("dec_pending_frames", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         pk = exp_q.pop_front();
         for (int n = 0; n < 14; n++) chk_eq("dec_byte", dec_cur[n], pk[8*n +: 8]);
      end
   endtask

   task automatic summary_and_finish();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   // Advance one clock: sample at the falling edge, run the model, compare, monitor.
   task automatic step();
      int b, pos;
      @(negedge CLK);
      model_edge(0);
      model_edge(1);
      if (RST) ecount = 0; else ecount++;

      chk_eq("i0_tx",   tx_w[0],   e_tx[0]);
      chk_eq("i0_busy", busy_w[0], e_busy[0]);
      chk_eq("i0_done", done_w[0], e_done[0]);
      chk_eq("i0_drop", drop_w[0], e_drop[0]);
      chk_eq("i1_tx",   tx_w[1],   e_tx[1]);
      chk_eq("i1_busy", busy_w[1], e_busy[1]);
      chk_eq("i1_done", done_w[1], e_done[1]);
      chk_eq("i1_drop", drop_w[1], e_drop[1]);

      if (RST) begin
         dec_on  = 1'b0;
         n_done0 = 0;
      end else begin
         if (!dec_on) begin
            if (prev_tx === 1'b1 && tx_w[0] === 1'b0) begin
               dec_on = 1'b1; dec_t = 0; cur_fall = ecount;
               dec_ferr = 0; dec_bad = 0; busy_len = 0;
            end
         end else begin
            dec_t++;
            if (tx_w[0] !== prev_tx && (dec_t % DIV) != 0) dec_bad++;
         end
         if (dec_on && (dec_t % DIV) == DIV / 2) begin
            b   = dec_t / DIV;
            pos = b % 10;
            if (pos == 0) begin
               if (tx_w[0] !== 1'b0) dec_ferr++;
            end else if (pos == 9) begin
               if (tx_w[0] !== 1'b1) dec_ferr++;
            end else begin
               dec_cur[b / 10][pos - 1] = tx_w[0];
            end
            if (b == 139) begin
               finish_frame();
               dec_on = 1'b0;
            end
         end
         if (busy_w[0]) busy_len++;
         if (done_w[0]) begin n_done0++; done_edge = ecount; end
         if (busy_w[1] && !prev_busy1) fall1_q.push_back(ecount);
         if (drop_w[1]) drop1_q.push_back(ecount);
      end
      prev_tx    = tx_w[0];
      prev_busy1 = busy_w[1];
      if (!tx_w[0]) win_txlow++;
      if (busy_w[0]) win_busy++;
      if (drop_w[0] || drop_w[1]) win_drop++;

      if (n_fail > 200) begin
         $display("FAIL too_many_failures: got %0d, limit 200", n_fail);
         summary_and_finish();
      end
   endtask

   task automatic run_until(input int target);
      for (int g = 0; g < target + 10 && ecount < target; g++) step();
   endtask

   function automatic logic [59:0] rand_counts();
      return 60'({$urandom(), $urandom()});
   endfunction

   initial begin
      int n_before;
      s1_exp = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};

      // Reset state.
      RST = 1'b1; EN = 1'b0; COUNTS = '0;
      repeat (3) step();
      chk_eq("rst_tx", tx_w[0], 1'b1);
      chk_eq("rst_busy", busy_w[0], 1'b0);

      // Channel k = k+1, EN high from reset release.
      EN = 1'b1;
      for (int k = 0; k < 12; k++) COUNTS[5*k +: 5] = 5'(k + 1);
      RST = 1'b0;
      run_until(5500);
      chk_eq("s1_fall_edge", dec_fall, 3000);
      for (int n = 0; n < 14; n++) chk_eq("s1_byte", last_dec[n], s1_exp[n]);
      chk_eq("s1_busy_cycles", busy_len, 2240);
      chk_eq("s1_done_edge", done_edge, 5240);
      chk_eq("s1_done_count", n_done0, 1);

      // All channels 1F, then 0 during byte 5 of the frame.
      COUNTS = '1;
      run_until(6100);
      chk_eq("s3_first_start", fall1_q[0], 2000);
      chk_eq("s3_drop_edge", drop1_q[0], 4000);
      chk_eq("s3_drop_count", drop1_q.size(), 1);
      chk_eq("s3_second_start", fall1_q[1], 6000);
      run_until(6840);
      COUNTS = '0;
      run_until(8400);
      chk_eq("s2_fall_edge", dec_fall, 6000);
      for (int n = 0; n < 14; n++)
         chk_eq("s2_byte", last_dec[n], (n == 0) ? 8'hA5 : (n == 13) ? 8'h00 : 8'h1F);
      run_until(11400);
      chk_eq("s2_next_fall_edge", dec_fall, 9000);
      for (int n = 0; n < 14; n++)
         chk_eq("s2_next_byte", last_dec[n], (n == 0) ? 8'hA5 : 8'h00);

      // EN low through three periods, then EN high; EN dropped again at byte 3.
      RST = 1'b1; EN = 1'b0;
      step();
      RST = 1'b0;
      win_txlow = 0; win_busy = 0; win_drop = 0;
      while (ecount < 9100) begin
         if (ecount % 50 == 0) COUNTS = rand_counts();
         step();
      end
      chk_eq("s4_tx_low_cycles", win_txlow, 0);
      chk_eq("s4_busy_cycles", win_busy, 0);
      chk_eq("s4_drop_pulses", win_drop, 0);
      EN = 1'b1;
      n_before = n_dec;
      run_until(12500);
      chk_eq("s4_first_start", cur_fall, 12000);
      EN = 1'b0;
      run_until(14400);
      chk_eq("s4_frame_completed", n_dec, n_before + 1);
      chk_eq("s4_fall_edge", dec_fall, 12000);
      win_busy = 0; win_drop = 0;
      run_until(15100);
      chk_eq("s4_ignored_tick_busy", win_busy, 0);
      chk_eq("s4_ignored_tick_drop", win_drop, 0);

      // Reset pulse during byte 7 data bits.
      EN = 1'b1;
      run_until(19173);
      chk_eq("s5_busy_before_reset", busy_w[0], 1'b1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk_eq("s5_tx_after_reset", tx_w[0], 1'b1);
      chk_eq("s5_busy_after_reset", busy_w[0], 1'b0);
      chk_eq("s5_done_after_reset", done_w[0], 1'b0);
      COUNTS = rand_counts();
      n_before = n_dec;
      run_until(5300);
      chk_eq("s5_restart_edge", dec_fall, 3000);
      chk_eq("s5_frames_decoded", n_dec, n_before + 1);
      chk_eq("s5_done_count", n_done0, 1);

      // Randomised soak: random counts, EN toggles and occasional reset pulses.
      for (int c = 0; c < 20000; c++) begin
         if ($urandom_range(0, 39) == 0) COUNTS = rand_counts();
         if ($urandom_range(0, 2999) == 0) EN = ~EN;
         RST = ($urandom_range(0, 9999) == 0);
         step();
      end
      RST = 1'b0;
      step();

      summary_and_finish();
   end

endmodule
